// File: rtl/io_write_arbiter.sv
// io_write_arbiter: arbitrates NREQ requesters onto the output buffer write port.
// Define IO_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module io_write_arbiter #(
    parameter int WIDTH = 13,
    parameter int NREQ  = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    input  logic                  buf_ready,
    output logic [WIDTH-1:0]      buf_data,
    output logic                  buf_write,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP_ST
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [7:0]       cnt;
    logic [7:0]       cnt_n;
    logic [NREQ-1:0]  gnt_n;
    logic [NREQ-1:0]  ack_n;
    logic [WIDTH-1:0] data_n;
    logic             wr_n;
    logic             found;
    logic [PW-1:0]    win;
    logic [WIDTH-1:0] win_data;

`ifndef IO_ARB_FIXED_PRIO_EN
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_n;
`endif

    // Winner search: scan order starts just after the last granted requester.
    always_comb begin : sel
        int idx;
        idx      = 0;
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef IO_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(ptr) + 1 + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
`endif
            for (int j = 0; j < NREQ; j++) begin
                if (!found && idx == j && req[j]) begin
                    found    = 1'b1;
                    win      = PW'(j);
                    win_data = req_data[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= '0;
            ack       <= '0;
            buf_data  <= '0;
            buf_write <= 1'b0;
            busy      <= 1'b0;
`ifndef IO_ARB_FIXED_PRIO_EN
            ptr       <= PW'(NREQ - 1);
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            ack       <= ack_n;
            buf_data  <= data_n;
            buf_write <= wr_n;
            busy      <= (state_n != IDLE);
`ifndef IO_ARB_FIXED_PRIO_EN
            ptr       <= ptr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (buf_ready && found) state_n = STROBE;
            STROBE:  if (cnt == 8'd0) state_n = GAP_ST;
            GAP_ST:  if (cnt == 8'd0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cnt_n  = cnt;
        gnt_n  = gnt;
        ack_n  = '0;
        data_n = buf_data;
        wr_n   = buf_write;
`ifndef IO_ARB_FIXED_PRIO_EN
        ptr_n  = ptr;
`endif
        unique case (state)
            IDLE: begin
                if (buf_ready && found) begin
                    data_n = win_data;
                    gnt_n  = NREQ'(1) << win;
                    wr_n   = 1'b1;
                    cnt_n  = 8'(HOLD - 1);
`ifndef IO_ARB_FIXED_PRIO_EN
                    ptr_n  = win;
`endif
                end
            end
            STROBE: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    wr_n  = 1'b0;
                    gnt_n = '0;
                    ack_n = gnt;
                    cnt_n = 8'(GAP - 1);
                end
            end
            GAP_ST: begin
                if (cnt != 8'd0)
                    cnt_n = cnt - 8'd1;
            end
            default: begin
                gnt_n = '0;
                wr_n  = 1'b0;
            end
        endcase
    end

endmodule
